// File: rtl/alu_pkg.sv
// Shared ALU definitions for the iterative multiply/divide sequencer.
// Provides the sequencer state enum, the operation enum and width/latency constants.
package alu_pkg;

   localparam int unsigned MD_WIDTH   = 32;
   localparam int unsigned MD_CNT_W   = 5;
   localparam int unsigned MD_LATENCY = 35;
   localparam logic [31:0] INT_MIN    = 32'h8000_0000;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      NEG_A = 3'd1,
      NEG_B = 3'd2,
      ITER  = 3'd3,
      FIX   = 3'd4,
      DONE  = 3'd5
   } md_state_t;

   typedef enum logic {
      OP_MULT = 1'b0,
      OP_DIV  = 1'b1
   } md_op_t;

endpackage

// File: rtl/multdiv_ctrl_iter_counter.sv
// Iteration counter for the multiply/divide sequencer.
// Ports: clock/reset (sync, active-high), clr (sync clear on start), en (count in ITER),
//        tc_c (combinational flag: count has reached LAST).
module md_iter_counter #(
   parameter int unsigned CNT_W = 5,
   parameter int unsigned LAST  = 31
) (
   input  logic clock,
   input  logic reset,
   input  logic clr,
   input  logic en,
   output logic tc_c
);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   // Clear wins over enable so a restart always begins from zero
   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (en) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign tc_c = (cnt_q == CNT_W'(LAST));

endmodule

// File: rtl/multdiv_ctrl.sv
// Iterative signed multiply/divide sequencer sharing one external adder.
// Ports: clock/reset (sync, active-high); ctrl_MULT/ctrl_DIV start pulses; data_operandA/B
//        sampled on start; add_opA/add_opB/add_cin drive the shared adder, add_sum/add_cout
//        return from it; data_result/data_exception valid with the one-cycle data_resultRDY.
module multdiv_ctrl
   import alu_pkg::*;
#(
   parameter int unsigned WIDTH = MD_WIDTH,
   parameter int unsigned CNT_W = MD_CNT_W
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             ctrl_MULT,
   input  logic             ctrl_DIV,
   input  logic [WIDTH-1:0] data_operandA,
   input  logic [WIDTH-1:0] data_operandB,
   output logic [WIDTH-1:0] add_opA,
   output logic [WIDTH-1:0] add_opB,
   output logic             add_cin,
   input  logic [WIDTH-1:0] add_sum,
   input  logic             add_cout,
   output logic [WIDTH-1:0] data_result,
   output logic             data_exception,
   output logic             data_resultRDY
);

   localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

   md_state_t        state_q, state_d;
   md_op_t           op_q, op_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] mag_a_q, mag_a_d;
   logic [WIDTH-1:0] mag_b_q, mag_b_d;
   logic [WIDTH-1:0] hi_q, hi_d;      // product high half / divide remainder
   logic [WIDTH-1:0] lo_q, lo_d;      // product low half / divide quotient
   logic [WIDTH-1:0] result_q, result_d;
   logic             exc_q, exc_d;
   logic             rdy_q, rdy_d;

   logic             start_c;
   logic             tc_c;
   logic             neg_c;
   logic [WIDTH-1:0] rs_c;

   assign start_c = ctrl_MULT | ctrl_DIV;
   assign neg_c   = a_q[WIDTH-1] ^ b_q[WIDTH-1];
   assign rs_c    = {hi_q[WIDTH-2:0], lo_q[WIDTH-1]};

   md_iter_counter #(
      .CNT_W (CNT_W),
      .LAST  (WIDTH - 1)
   ) u_iter_counter (
      .clock (clock),
      .reset (reset),
      .clr   (start_c),
      .en    (state_q == ITER),
      .tc_c  (tc_c)
   );

   // State register
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next state; a start in any state restarts the sequence
   always_comb begin
      state_d = state_q;
      if (start_c) begin
         state_d = NEG_A;
      end else begin
         case (state_q)
            IDLE:    state_d = IDLE;
            NEG_A:   state_d = NEG_B;
            NEG_B:   state_d = ITER;
            ITER:    state_d = tc_c ? FIX : ITER;
            FIX:     state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
         endcase
      end
   end

   // Shared adder operands per state; idle states present zeros
   always_comb begin
      add_opA = '0;
      add_opB = '0;
      add_cin = 1'b0;
      case (state_q)
         NEG_A: begin
            add_opA = ~a_q;
            add_cin = 1'b1;
         end
         NEG_B: begin
            add_opA = ~b_q;
            add_cin = 1'b1;
         end
         ITER: begin
            if (op_q == OP_MULT) begin
               add_opA = hi_q;
               add_opB = lo_q[0] ? mag_a_q : '0;
            end else begin
               // Trial subtract: carry-out set means shifted remainder >= divisor
               add_opA = rs_c;
               add_opB = ~mag_b_q;
               add_cin = 1'b1;
            end
         end
         FIX: begin
            add_opA = ~lo_q;
            add_cin = 1'b1;
         end
         default: ;
      endcase
   end

   // Datapath next values
   always_comb begin
      op_d     = op_q;
      a_d      = a_q;
      b_d      = b_q;
      mag_a_d  = mag_a_q;
      mag_b_d  = mag_b_q;
      hi_d     = hi_q;
      lo_d     = lo_q;
      result_d = result_q;
      exc_d    = exc_q;
      rdy_d    = 1'b0;
      if (start_c) begin
         op_d = ctrl_MULT ? OP_MULT : OP_DIV;
         a_d  = data_operandA;
         b_d  = data_operandB;
      end else begin
         case (state_q)
            NEG_A: begin
               mag_a_d = a_q[WIDTH-1] ? add_sum : a_q;
            end
            NEG_B: begin
               mag_b_d = b_q[WIDTH-1] ? add_sum : b_q;
               hi_d    = '0;
               lo_d    = (op_q == OP_MULT) ? (b_q[WIDTH-1] ? add_sum : b_q) : mag_a_q;
            end
            ITER: begin
               if (op_q == OP_MULT) begin
                  {hi_d, lo_d} = {add_cout, add_sum, lo_q[WIDTH-1:1]};
               end else if (add_cout) begin
                  hi_d = add_sum;
                  lo_d = {lo_q[WIDTH-2:0], 1'b1};
               end else begin
                  hi_d = rs_c;
                  lo_d = {lo_q[WIDTH-2:0], 1'b0};
               end
            end
            FIX: begin
               rdy_d    = 1'b1;
               result_d = neg_c ? add_sum : lo_q;
               exc_d    = 1'b0;
               if (op_q == OP_MULT) begin
                  // Magnitude 2^31 is representable only as a negative result
                  exc_d = (hi_q != '0) || (lo_q[WIDTH-1] && !(neg_c && (lo_q == MIN_VAL)));
               end else if (b_q == '0) begin
                  result_d = '0;
                  exc_d    = 1'b1;
               end else if ((a_q == MIN_VAL) && (b_q == '1)) begin
                  result_d = MIN_VAL;
                  exc_d    = 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   // Datapath registers
   always_ff @(posedge clock) begin
      if (reset) begin
         op_q     <= OP_MULT;
         a_q      <= '0;
         b_q      <= '0;
         mag_a_q  <= '0;
         mag_b_q  <= '0;
         hi_q     <= '0;
         lo_q     <= '0;
         result_q <= '0;
         exc_q    <= 1'b0;
         rdy_q    <= 1'b0;
      end else begin
         op_q     <= op_d;
         a_q      <= a_d;
         b_q      <= b_d;
         mag_a_q  <= mag_a_d;
         mag_b_q  <= mag_b_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
         result_q <= result_d;
         exc_q    <= exc_d;
         rdy_q    <= rdy_d;
      end
   end

   assign data_result    = result_q;
   assign data_exception = exc_q;
   assign data_resultRDY = rdy_q;

endmodule
